// File: rtl/debug_cmd_sched_pkg.sv
// Shared types for the host debug command scheduler: command codes, the
// scheduler state encoding and the command legality check.
package debug_pkg;

  localparam int CMD_PKG_W = 4;

  typedef enum logic [CMD_PKG_W-1:0] {
    CMD_IDLE  = 4'd0,
    CMD_RUN   = 4'd1,
    CMD_STEPI = 4'd2,
    CMD_STEPC = 4'd3
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_EXITED = 2'd3
  } sched_state_e;

  // Takes a zero-extended code so callers with any CMD_W can share it.
  function automatic logic is_legal_cmd(input logic [31:0] code);
    return (code == 32'(CMD_RUN)) || (code == 32'(CMD_STEPI)) ||
           (code == 32'(CMD_STEPC));
  endfunction

endpackage

// File: rtl/debug_cmd_fifo.sv
// Synchronous command FIFO with occupancy count and a flush that empties it
// in one cycle. Pushes when full and pops when empty are ignored.
module debug_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int CMD_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [CMD_W-1:0]         wdata,
  output logic [CMD_W-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count need defined values.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-two depth lets the pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/debug_cmd_sched.sv
// Host-side debug command scheduler: queues host commands and issues them one
// at a time to the harness. Watchdog enabled by DEBUG_CMD_SCHED_TIMEOUT_EN.
module debug_cmd_sched
  import debug_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int CMD_W          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   host_cmd_valid,
  input  logic [CMD_W-1:0]       host_cmd,
  output logic                   host_cmd_ready,
  input  logic                   err_clear,
  input  logic                   command_complete,
  input  logic                   exit_signal,
  output logic [CMD_W-1:0]       debug_cmd,
  output logic                   cmd_done,
  output logic [CMD_W-1:0]       cmd_done_code,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   illegal_err,
  output logic                   timeout_err,
  output logic                   exited
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("debug_cmd_sched: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("debug_cmd_sched: TIMEOUT_CYCLES must be >= 2");
  end

  sched_state_e     state;
  logic [CMD_W-1:0] cur_cmd;
  logic [CMD_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             flush;
  logic             head_legal;
  logic             timer_expired;

  assign host_cmd_ready = !fifo_full && (state != S_EXITED);
  assign push           = host_cmd_valid && host_cmd_ready;
  assign pop            = (state == S_IDLE) && !fifo_empty && !exit_signal;
  // Flushing on the exit cycle itself makes count read 0 as exited rises.
  assign flush          = exit_signal || (state == S_EXITED);
  assign head_legal     = is_legal_cmd(32'(fifo_head));
  assign busy           = (state != S_IDLE) || !fifo_empty;
  assign exited         = (state == S_EXITED);

  debug_cmd_fifo #(
    .DEPTH (DEPTH),
    .CMD_W (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (host_cmd),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef DEBUG_CMD_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] timer;

  assign timer_expired = (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_ISSUE) begin
        timer <= '0;
      end else if (state == S_WAIT) begin
        timer <= timer + TW'(1);
      end
      // Completion and exit both outrank the watchdog.
      if (state == S_WAIT && !command_complete && !exit_signal && timer_expired) begin
        timeout_err <= 1'b1;
      end else if (err_clear) begin
        timeout_err <= 1'b0;
      end
    end
  end
`else
  assign timer_expired = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cur_cmd       <= '0;
      debug_cmd     <= '0;
      cmd_done      <= 1'b0;
      cmd_done_code <= '0;
      illegal_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments
      // in the case below, which turns debug_cmd and cmd_done into pulses.
      debug_cmd <= '0;
      cmd_done  <= 1'b0;
      if (err_clear) illegal_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (exit_signal) begin
            state <= S_EXITED;
          end else if (!fifo_empty) begin
            cur_cmd <= fifo_head;
            if (head_legal) begin
              debug_cmd <= fifo_head;
              state     <= S_ISSUE;
            end else begin
              illegal_err   <= 1'b1;
              cmd_done      <= 1'b1;
              cmd_done_code <= fifo_head;
            end
          end
        end
        S_ISSUE: begin
          state <= exit_signal ? S_EXITED : S_WAIT;
        end
        S_WAIT: begin
          if (command_complete) begin
            cmd_done      <= 1'b1;
            cmd_done_code <= cur_cmd;
            state         <= exit_signal ? S_EXITED : S_IDLE;
          end else if (exit_signal) begin
            state <= S_EXITED;
          end else if (timer_expired) begin
            cmd_done      <= 1'b1;
            cmd_done_code <= cur_cmd;
            state         <= S_IDLE;
          end
        end
        S_EXITED: state <= S_EXITED;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
